// File: rtl/wasca_audio_pkg.sv
// Shared constants for the wasca audio output block: register map, bit positions
// and synchroniser depth.
package wasca_audio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_THRESH  = 2'd3;

  localparam int unsigned STAT_EMPTY = 16;
  localparam int unsigned STAT_FULL  = 17;
  localparam int unsigned STAT_UNDR  = 18;
  localparam int unsigned STAT_OVF   = 19;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_FLUSH  = 2;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock show-ahead FIFO of stereo sample words. Pushes while full are
// dropped; flush empties it in one cycle and wins over a concurrent push/pop.
module audio_sample_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;
  logic [LW-1:0]    level_nxt_c;

  always_comb begin
    do_push_c   = push & ~full & ~flush;
    do_pop_c    = pop & ~empty & ~flush;
    level_nxt_c = level + LW'(do_push_c) - LW'(do_pop_c);
    if (flush) level_nxt_c = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push_c) wr_ptr <= AW'(wr_ptr + 1'b1);
        if (do_pop_c)  rd_ptr <= AW'(rd_ptr + 1'b1);
      end
      level <= level_nxt_c;
      empty <= (level_nxt_c == '0);
      full  <= (level_nxt_c == LW'(DEPTH));
    end
  end

  // Storage needs no reset; contents are only visible through valid pointers.
  always_ff @(posedge clock) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/audio_i2s_dac_out.sv
// Avalon-MM audio output: CPU-filled sample FIFO serialised as I2S (MSB first,
// one-BCLK delay) against codec-mastered BCLK/LRCK, with status and low-water irq.
module audio_i2s_dac_out
  import wasca_audio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned SLOT_W     = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        irq,
  input  logic        audio_bclk,
  input  logic        audio_lrck,
  output logic        audio_dacdat
);

  localparam int unsigned FW = 2 * SAMPLE_W;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = $clog2(SLOT_W + 1);

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync;
  logic                   bclk_q, lrck_q;
  logic                   bclk_fall_c, lrck_fall_c, lrck_rise_c;

  logic          en, irq_en, undr, ovf;
  logic [15:0]   thresh;
  logic [FW-1:0] fifo_dout;
  logic [LW-1:0] fifo_level;
  logic          fifo_empty, fifo_full;

  logic [FW-1:0]       hold;
  logic [SAMPLE_W-1:0] shift;
  logic [CW-1:0]       cnt;

  logic wr_data_c, wr_status_c, wr_ctrl_c, wr_thresh_c, flush_c;
  logic pop_c, undr_set_c, ovf_set_c;
  logic [FW-1:0] push_word_c;
  logic [31:0]   status_c, ctrl_c, rd_c;

  // Two-flop synchronisers followed by an edge-detect register.
  always_ff @(posedge clock) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], audio_bclk};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], audio_lrck};
      bclk_q    <= bclk_sync[SYNC_STAGES-1];
      lrck_q    <= lrck_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    bclk_fall_c = bclk_q & ~bclk_sync[SYNC_STAGES-1];
    lrck_fall_c = lrck_q & ~lrck_sync[SYNC_STAGES-1];
    lrck_rise_c = ~lrck_q & lrck_sync[SYNC_STAGES-1];

    wr_data_c   = avs_write & (avs_address == ADDR_DATA);
    wr_status_c = avs_write & (avs_address == ADDR_STATUS);
    wr_ctrl_c   = avs_write & (avs_address == ADDR_CONTROL);
    wr_thresh_c = avs_write & (avs_address == ADDR_THRESH);
    flush_c     = wr_ctrl_c & avs_writedata[CTRL_FLUSH];
    push_word_c = {avs_writedata[31 -: SAMPLE_W], avs_writedata[15 -: SAMPLE_W]};

    pop_c      = lrck_fall_c & en & ~fifo_empty & ~flush_c;
    undr_set_c = lrck_fall_c & en & (fifo_empty | flush_c);
    ovf_set_c  = wr_data_c & fifo_full;

    status_c              = 32'(16'(fifo_level));
    status_c[STAT_EMPTY]  = fifo_empty;
    status_c[STAT_FULL]   = fifo_full;
    status_c[STAT_UNDR]   = undr;
    status_c[STAT_OVF]    = ovf;
    ctrl_c                = '0;
    ctrl_c[CTRL_EN]       = en;
    ctrl_c[CTRL_IRQ_EN]   = irq_en;

    case (avs_address)
      ADDR_DATA:    rd_c = '0;
      ADDR_STATUS:  rd_c = status_c;
      ADDR_CONTROL: rd_c = ctrl_c;
      default:      rd_c = 32'(thresh);
    endcase
  end

  audio_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_data_c),
    .pop   (pop_c),
    .flush (flush_c),
    .din   (push_word_c),
    .dout  (fifo_dout),
    .level (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Register file, sticky flags (set beats W1C) and interrupt.
  always_ff @(posedge clock) begin
    if (reset) begin
      en           <= 1'b0;
      irq_en       <= 1'b0;
      thresh       <= 16'(FIFO_DEPTH / 2);
      undr         <= 1'b0;
      ovf          <= 1'b0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (wr_ctrl_c) begin
        en     <= avs_writedata[CTRL_EN];
        irq_en <= avs_writedata[CTRL_IRQ_EN];
      end
      if (wr_thresh_c) thresh <= avs_writedata[15:0];
      undr <= undr_set_c | (undr & ~(wr_status_c & avs_writedata[STAT_UNDR]));
      ovf  <= ovf_set_c | (ovf & ~(wr_status_c & avs_writedata[STAT_OVF]));
      irq  <= irq_en & ((16'(fifo_level) <= thresh) | undr);
      if (avs_read) avs_readdata <= rd_c;
    end
  end

  // Serialiser: an LRCK edge reloads the channel; a coincident BCLK fall is the delay bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold         <= '0;
      shift        <= '0;
      cnt          <= CW'(SLOT_W);
      audio_dacdat <= 1'b0;
    end else if (lrck_fall_c || lrck_rise_c) begin
      if (lrck_fall_c) begin
        hold  <= pop_c ? fifo_dout : '0;
        shift <= pop_c ? fifo_dout[FW-1 -: SAMPLE_W] : '0;
      end else begin
        shift <= hold[SAMPLE_W-1:0];
      end
      cnt <= bclk_fall_c ? CW'(1) : '0;
      if (bclk_fall_c) audio_dacdat <= 1'b0;
    end else if (bclk_fall_c) begin
      if (cnt != '0 && cnt <= CW'(SAMPLE_W)) begin
        audio_dacdat <= shift[SAMPLE_W-1];
        shift        <= {shift[SAMPLE_W-2:0], 1'b0};
      end else begin
        audio_dacdat <= 1'b0;
      end
      if (cnt != CW'(SLOT_W)) cnt <= cnt + CW'(1);
    end
  end

endmodule
